buzz_arbiter: RTL and testbench

Round arbiter for the quiz-buzzer game: it consumes the confirmed player count from the player-setup stage (3-bit code 2/3/4) and the per-player buzzer buttons. It arms a round on `start`, grants the first valid buzz, and runs an answer countdown. It also flags early buzzes as fouls and holds the result for the display stage until `clear`.

---
 rtl/buzz_arbiter_if.sv | 25 ++
 rtl/buzz_arbiter.sv | 139 +++++++++++++
 tb/tb_buzz_arbiter.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/buzz_arbiter_if.sv
// Signal bundle between the quiz-buzzer round arbiter and its environment.
// The slave modport is the arbiter side; master drives the round controls.
interface buzz_arbiter_if;
    logic [2:0] player_cnt;
    logic       start;
    logic       clear;
    logic [3:0] btn;
    logic       tick;
    logic [2:0] winner;
    logic       answering;
    logic       timeout;
    logic [3:0] remain;
    logic [3:0] foul;
    logic [1:0] state;

    modport slave (
        input  player_cnt, start, clear, btn, tick,
        output winner, answering, timeout, remain, foul, state
    );

    modport master (
        output player_cnt, start, clear, btn, tick,
        input  winner, answering, timeout, remain, foul, state
    );
endinterface

// File: rtl/buzz_arbiter.sv
// Quiz-buzzer round arbiter: arms on start, grants the first valid press,
// runs the answer countdown and records early-buzz fouls until clear.
module buzz_arbiter #(
    parameter int unsigned ANSWER_TICKS = 10
) (
    input logic           clk,
    input logic           rst,
    buzz_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StArmed  = 2'd1,
        StAnswer = 2'd2,
        StDone   = 2'd3
    } state_e;

    localparam logic [3:0] AnswerInit = 4'(ANSWER_TICKS);

    state_e     state_q, state_d;
    logic [3:0] btn_q, btn_d;
    logic [3:0] mask_q, mask_d;
    logic [2:0] winner_q, winner_d;
    logic       answering_q, answering_d;
    logic       timeout_q, timeout_d;
    logic [3:0] remain_q, remain_d;
    logic [3:0] foul_q, foul_d;

    logic [3:0] live_mask;
    logic [3:0] act_mask;
    logic [3:0] press;
    logic [3:0] cand;
    logic [2:0] cand_idx;

    // Unknown player-count codes fall back to a two-player game.
    always_comb begin
        unique case (bus.player_cnt)
            3'b011:  live_mask = 4'b0111;
            3'b100:  live_mask = 4'b1111;
            default: live_mask = 4'b0011;
        endcase
    end

    assign act_mask = (state_q == StIdle) ? live_mask : mask_q;
    assign press    = bus.btn & ~btn_q & act_mask;
    assign cand     = press & ~foul_q;

    // Lowest-numbered candidate wins simultaneous presses.
    always_comb begin
        cand_idx = 3'd0;
        for (int i = 3; i >= 0; i--) begin
            if (cand[i]) cand_idx = 3'(i + 1);
        end
    end

    always_comb begin
        state_d     = state_q;
        btn_d       = bus.btn;
        mask_d      = mask_q;
        winner_d    = winner_q;
        answering_d = answering_q;
        timeout_d   = timeout_q;
        remain_d    = remain_q;
        foul_d      = foul_q;

        if (bus.clear) begin
            state_d     = StIdle;
            winner_d    = 3'd0;
            answering_d = 1'b0;
            timeout_d   = 1'b0;
            remain_d    = 4'd0;
            foul_d      = 4'd0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    foul_d = foul_q | press;
                    if (bus.start) begin
                        state_d = StArmed;
                        mask_d  = live_mask;
                    end
                end
                StArmed: begin
                    if (cand != 4'd0) begin
                        state_d     = StAnswer;
                        winner_d    = cand_idx;
                        remain_d    = AnswerInit;
                        answering_d = 1'b1;
                    end
                end
                StAnswer: begin
                    if (bus.tick) begin
                        if (remain_q <= 4'd1) begin
                            state_d     = StDone;
                            remain_d    = 4'd0;
                            answering_d = 1'b0;
                            timeout_d   = 1'b1;
                        end else begin
                            remain_d = remain_q - 4'd1;
                        end
                    end
                end
                StDone: begin
                    remain_d = 4'd0;
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= StIdle;
            btn_q       <= 4'd0;
            mask_q      <= 4'b0011;
            winner_q    <= 3'd0;
            answering_q <= 1'b0;
            timeout_q   <= 1'b0;
            remain_q    <= 4'd0;
            foul_q      <= 4'd0;
        end else begin
            state_q     <= state_d;
            btn_q       <= btn_d;
            mask_q      <= mask_d;
            winner_q    <= winner_d;
            answering_q <= answering_d;
            timeout_q   <= timeout_d;
            remain_q    <= remain_d;
            foul_q      <= foul_d;
        end
    end

    assign bus.winner    = winner_q;
    assign bus.answering = answering_q;
    assign bus.timeout   = timeout_q;
    assign bus.remain    = remain_q;
    assign bus.foul      = foul_q;
    assign bus.state     = state_q;

endmodule

// File: tb/tb_buzz_arbiter.sv
// Directed bench for buzz_arbiter: expected outputs are queued as each step
// is driven and checked one cycle later after the clock edge.
module tb_buzz_arbiter;

    logic clk;
    logic rst;
    int   tests;
    int   fails;

    buzz_arbiter_if bus ();

    buzz_arbiter #(.ANSWER_TICKS(10)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {winner, answering, timeout, remain, foul, state}
    logic [14:0] exp_q[$];
    string       tag_q[$];

    task automatic expect_out(input string tag, input logic [2:0] w, input logic a,
                              input logic t, input logic [3:0] r, input logic [3:0] f,
                              input logic [1:0] s);
        exp_q.push_back({w, a, t, r, f, s});
        tag_q.push_back(tag);
    endtask

    task automatic drive(input logic [2:0] pc, input logic st, input logic cl,
                         input logic [3:0] b, input logic tk);
        bus.player_cnt = pc;
        bus.start      = st;
        bus.clear      = cl;
        bus.btn        = b;
        bus.tick       = tk;
    endtask

    task automatic step();
        logic [14:0] obs;
        logic [14:0] expv;
        string       tag;
        @(posedge clk);
        #1;
        obs = {bus.winner, bus.answering, bus.timeout, bus.remain, bus.foul, bus.state};
        while (exp_q.size() > 0) begin
            expv = exp_q.pop_front();
            tag  = tag_q.pop_front();
            tests++;
            assert (obs === expv)
            else begin
                fails++;
                $error("FAIL %s: observed w/a/t/r/f/s=%0d/%0b/%0b/%0d/%b/%0d required %0d/%0b/%0b/%0d/%b/%0d",
                       tag, obs[14:12], obs[11], obs[10], obs[9:6], obs[5:2], obs[1:0],
                       expv[14:12], expv[11], expv[10], expv[9:6], expv[5:2], expv[1:0]);
            end
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;

        // Reset
        rst = 1'b0;
        drive(3'b010, 1'b0, 1'b0, 4'b0000, 1'b0);
        expect_out("reset", 3'd0, 1'b0, 1'b0, 4'd0, 4'd0, 2'd0);
        step();
        rst = 1'b1;

        // Reset during ANSWER with remain 7, winner 3
        drive(3'b011, 1'b1, 1'b0, 4'b0000, 1'b0);
        expect_out("a_armed", 3'd0, 1'b0, 1'b0, 4'd0, 4'd0, 2'd1);
        step();
        drive(3'b011, 1'b0, 1'b0, 4'b0100, 1'b0);
        expect_out("a_grant3", 3'd3, 1'b1, 1'b0, 4'd10, 4'd0, 2'd2);
        step();
        for (int i = 0; i < 3; i++) begin
            bus.tick = 1'b1;
            step();
            bus.tick = 1'b0;
            step();
        end
        expect_out("a_remain7", 3'd3, 1'b1, 1'b0, 4'd7, 4'd0, 2'd2);
        step();
        rst = 1'b0;
        drive(3'b011, 1'b0, 1'b0, 4'b0000, 1'b0);
        expect_out("a_reset_mid", 3'd0, 1'b0, 1'b0, 4'd0, 4'd0, 2'd0);
        step();
        rst = 1'b1;
        drive(3'b011, 1'b1, 1'b0, 4'b0000, 1'b0);
        expect_out("a_restart", 3'd0, 1'b0, 1'b0, 4'd0, 4'd0, 2'd1);
        step();
        drive(3'b011, 1'b0, 1'b1, 4'b0000, 1'b0);
        expect_out("a_clear", 3'd0, 1'b0, 1'b0, 4'd0, 4'd0, 2'd0);
        step();

        // Three players, simultaneous presses 2 and 3; later press 1 ignored
        drive(3'b011, 1'b1, 1'b0, 4'b0000, 1'b0);
        expect_out("b_armed", 3'd0, 1'b0, 1'b0, 4'd0, 4'd0, 2'd1);
        step();
        drive(3'b011, 1'b0, 1'b0, 4'b0110, 1'b0);
        expect_out("b_grant2", 3'd2, 1'b1, 1'b0, 4'd10, 4'd0, 2'd2);
        step();
        drive(3'b011, 1'b0, 1'b0, 4'b0111, 1'b0);
        expect_out("b_hold2", 3'd2, 1'b1, 1'b0, 4'd10, 4'd0, 2'd2);
        step();
        drive(3'b011, 1'b1, 1'b1, 4'b0000, 1'b0);
        expect_out("b_clear", 3'd0, 1'b0, 1'b0, 4'd0, 4'd0, 2'd0);
        step();

        // Two players: inactive player 4 ignored in ARMED
        drive(3'b010, 1'b1, 1'b0, 4'b0000, 1'b0);
        expect_out("c_armed", 3'd0, 1'b0, 1'b0, 4'd0, 4'd0, 2'd1);
        step();
        drive(3'b100, 1'b0, 1'b0, 4'b1000, 1'b0);
        expect_out("c_ignore4", 3'd0, 1'b0, 1'b0, 4'd0, 4'd0, 2'd1);
        step();
        drive(3'b100, 1'b0, 1'b0, 4'b1001, 1'b0);
        expect_out("c_grant1", 3'd1, 1'b1, 1'b0, 4'd10, 4'd0, 2'd2);
        step();
        drive(3'b010, 1'b0, 1'b1, 4'b0000, 1'b0);
        expect_out("c_clear", 3'd0, 1'b0, 1'b0, 4'd0, 4'd0, 2'd0);
        step();

        // Foul in IDLE excludes player 2; tick at grant edge ignored
        drive(3'b011, 1'b0, 1'b0, 4'b0010, 1'b0);
        expect_out("d_foul", 3'd0, 1'b0, 1'b0, 4'd0, 4'b0010, 2'd0);
        step();
        drive(3'b011, 1'b1, 1'b0, 4'b0000, 1'b0);
        expect_out("d_armed", 3'd0, 1'b0, 1'b0, 4'd0, 4'b0010, 2'd1);
        step();
        drive(3'b011, 1'b0, 1'b0, 4'b0011, 1'b1);
        expect_out("d_grant1", 3'd1, 1'b1, 1'b0, 4'd10, 4'b0010, 2'd2);
        step();
        bus.tick = 1'b0;
        step();

        // Countdown 10 -> 0 and timeout
        for (int i = 1; i <= 10; i++) begin
            bus.tick = 1'b1;
            if (i == 10)
                expect_out("e_timeout", 3'd1, 1'b0, 1'b1, 4'd0, 4'b0010, 2'd3);
            else
                expect_out("e_count", 3'd1, 1'b1, 1'b0, 4'(10 - i), 4'b0010, 2'd2);
            step();
            bus.tick = 1'b0;
            step();
        end
        bus.tick = 1'b1;
        expect_out("e_tick11", 3'd1, 1'b0, 1'b1, 4'd0, 4'b0010, 2'd3);
        step();
        bus.tick = 1'b0;

        // clear beats start in DONE; start the next cycle arms
        drive(3'b011, 1'b1, 1'b1, 4'b0011, 1'b0);
        expect_out("f_clear_start", 3'd0, 1'b0, 1'b0, 4'd0, 4'd0, 2'd0);
        step();
        drive(3'b011, 1'b1, 1'b0, 4'b0011, 1'b0);
        expect_out("f_start", 3'd0, 1'b0, 1'b0, 4'd0, 4'd0, 2'd1);
        step();
        drive(3'b011, 1'b0, 1'b0, 4'b0011, 1'b0);
        step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
